// File: rtl/sram_i_fetch.sv
// sram_i_fetch: read-side sequencer for the input feature SRAM.
// Sweeps the map (optional zero border) and streams tagged words.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start             sweep request (honoured only when idle)
//   busy, done        sweep in progress / one-cycle completion pulse
//   sram_addr/we/dout SRAM read port (1-cycle registered read)
//   pix_*             valid/ready output stream with row/col/last tags
module sram_i_fetch #(
  parameter int MAP_W        = 56,
  parameter int MAP_H        = 56,
  parameter int BIT_PER_WORD = 145,
  parameter int ADDR_W       = 12,
  parameter int PAD          = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic                    sram_we,
  input  logic [BIT_PER_WORD-1:0] sram_dout,
  output logic [BIT_PER_WORD-1:0] pix_data,
  output logic [7:0]              pix_row,
  output logic [7:0]              pix_col,
  output logic                    pix_last,
  output logic                    pix_valid,
  input  logic                    pix_ready
);

  localparam int OH = MAP_H + 2 * PAD;
  localparam int OW = MAP_W + 2 * PAD;
  localparam logic [7:0] ROW_LAST = 8'(OH - 1);
  localparam logic [7:0] COL_LAST = 8'(OW - 1);
  localparam logic [7:0] PAD8 = 8'(PAD);
  localparam logic [7:0] H8   = 8'(MAP_H);
  localparam logic [7:0] W8   = 8'(MAP_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic [ADDR_W-1:0] r_ia;
  logic [ADDR_W-1:0] r_hold;

  logic              r_inf;
  logic              r_inf_pad;
  logic [7:0]        r_inf_row;
  logic [7:0]        r_inf_col;
  logic              r_inf_last;

  logic [BIT_PER_WORD-1:0] r_fd [2];
  logic [7:0]              r_fr [2];
  logic [7:0]              r_fc [2];
  logic                    r_fl [2];
  logic                    r_wp;
  logic                    r_rp;
  logic [1:0]              r_cnt;

  logic [7:0]              w_row_off;
  logic [7:0]              w_col_off;
  logic                    w_int;
  logic                    w_last_pos;
  logic                    w_credit;
  logic                    w_issue;
  logic [BIT_PER_WORD-1:0] w_in_data;
  logic                    w_valid;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_xfer;
  logic [BIT_PER_WORD-1:0] w_h_data;
  logic [7:0]              w_h_row;
  logic [7:0]              w_h_col;
  logic                    w_h_last;

  // Unsigned wrap makes positions above the top/left border fail the
  // range test as well, so one compare per axis covers both sides.
  assign w_row_off  = r_row - PAD8;
  assign w_col_off  = r_col - PAD8;
  assign w_int      = (w_row_off < H8) && (w_col_off < W8);
  assign w_last_pos = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Credit uses only registered state, keeping pix_ready off the
  // address path.
  assign w_credit = ({1'b0, r_cnt} + {2'b00, r_inf}) < 3'd2;
  assign w_issue  = (r_state == S_RUN) && w_credit;

  assign sram_addr = (w_issue && w_int) ? r_ia : r_hold;
  assign sram_we   = 1'b0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

  // The in-flight word falls through when the FIFO is empty, so a beat
  // is visible in the cycle its SRAM data returns.
  assign w_in_data = r_inf_pad ? '0 : sram_dout;
  assign w_valid   = (r_cnt != 2'd0) || r_inf;
  assign w_pop     = (r_cnt != 2'd0) && pix_ready;
  assign w_push    = r_inf && !((r_cnt == 2'd0) && pix_ready);
  assign w_xfer    = w_valid && pix_ready;

  always_comb begin
    w_h_data = '0;
    w_h_row  = '0;
    w_h_col  = '0;
    w_h_last = 1'b0;
    if (r_cnt != 2'd0) begin
      w_h_data = r_fd[r_rp];
      w_h_row  = r_fr[r_rp];
      w_h_col  = r_fc[r_rp];
      w_h_last = r_fl[r_rp];
    end else if (r_inf) begin
      w_h_data = w_in_data;
      w_h_row  = r_inf_row;
      w_h_col  = r_inf_col;
      w_h_last = r_inf_last;
    end
  end

  assign pix_valid = w_valid;
  assign pix_data  = w_h_data;
  assign pix_row   = w_h_row;
  assign pix_col   = w_h_col;
  assign pix_last  = w_h_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_ia    <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_state <= S_RUN;
        S_RUN: if (w_issue && w_last_pos) r_state <= S_DRAIN;
        S_DRAIN: if (w_xfer && w_h_last) r_state <= S_DONE;
        default: begin
          r_state <= S_IDLE;
          r_row   <= '0;
          r_col   <= '0;
          r_ia    <= '0;
          r_hold  <= '0;
        end
      endcase
      if (w_issue) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? 8'd0 : r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
        if (w_int) begin
          r_ia   <= r_ia + ADDR_W'(1);
          r_hold <= r_ia;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inf      <= 1'b0;
      r_inf_pad  <= 1'b0;
      r_inf_row  <= '0;
      r_inf_col  <= '0;
      r_inf_last <= 1'b0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_inf <= w_issue;
      if (w_issue) begin
        r_inf_pad  <= !w_int;
        r_inf_row  <= r_row;
        r_inf_col  <= r_col;
        r_inf_last <= w_last_pos;
      end
      if (w_push) r_wp <= !r_wp;
      if (w_pop)  r_rp <= !r_rp;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fd[r_wp] <= w_in_data;
      r_fr[r_wp] <= r_inf_row;
      r_fc[r_wp] <= r_inf_col;
      r_fl[r_wp] <= r_inf_last;
    end
  end

endmodule

// File: tb/tb_sram_i_fetch.sv
// tb_sram_i_fetch: directed + randomized bench for sram_i_fetch.
// Two instances (PAD=0, PAD=1) share a random SRAM image.
module tb_sram_i_fetch;
  localparam int W   = 56;
  localparam int H   = 56;
  localparam int BPW = 145;
  localparam int AW  = 12;
  localparam int NW  = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ready, sel;
  logic start0, start1;
  assign start0 = start && !sel;
  assign start1 = start && sel;

  logic busy0, busy1, done0, done1, we0, we1;
  logic last0, last1, val0, val1;
  logic [AW-1:0]  addr0, addr1;
  logic [BPW-1:0] dout0, dout1, data0, data1;
  logic [7:0]     row0, row1, col0, col1;

  logic [BPW-1:0] mem [NW];

  always_ff @(posedge clk) begin
    dout0 <= mem[addr0];
    dout1 <= mem[addr1];
  end

  sram_i_fetch #(.PAD(0)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0),
    .sram_addr(addr0), .sram_we(we0), .sram_dout(dout0),
    .pix_data(data0), .pix_row(row0), .pix_col(col0),
    .pix_last(last0), .pix_valid(val0), .pix_ready(ready)
  );

  sram_i_fetch #(.PAD(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1),
    .sram_addr(addr1), .sram_we(we1), .sram_dout(dout1),
    .pix_data(data1), .pix_row(row1), .pix_col(col1),
    .pix_last(last1), .pix_valid(val1), .pix_ready(ready)
  );

  logic o_busy, o_done, o_we, o_last, o_valid;
  logic [AW-1:0]  o_addr;
  logic [BPW-1:0] o_data;
  logic [7:0]     o_row, o_col;
  assign o_busy  = sel ? busy1 : busy0;
  assign o_done  = sel ? done1 : done0;
  assign o_we    = sel ? we1 : we0;
  assign o_last  = sel ? last1 : last0;
  assign o_valid = sel ? val1 : val0;
  assign o_addr  = sel ? addr1 : addr0;
  assign o_data  = sel ? data1 : data0;
  assign o_row   = sel ? row1 : row0;
  assign o_col   = sel ? col1 : col0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [169:0] obs,
                     input logic [169:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_int(input int pad, input int k);
    int ow, r, c;
    ow = W + 2 * pad;
    r = k / ow;
    c = k % ow;
    return (r >= pad) && (r < H + pad) && (c >= pad) && (c < W + pad);
  endfunction

  function automatic int int_addr(input int pad, input int k);
    int ow;
    ow = W + 2 * pad;
    return (k / ow - pad) * W + (k % ow - pad);
  endfunction

  function automatic logic [BPW-1:0] exp_data(input int pad, input int k);
    if (!is_int(pad, k)) return '0;
    return mem[int_addr(pad, k)];
  endfunction

  function automatic int last_int_addr(input int pad, input int idx);
    for (int j = idx; j >= 0; j--)
      if (is_int(pad, j)) return int_addr(pad, j);
    return 0;
  endfunction

  task automatic reset_vals();
    chk("rst_busy",  170'(o_busy),  170'(0));
    chk("rst_done",  170'(o_done),  170'(0));
    chk("rst_valid", 170'(o_valid), 170'(0));
    chk("rst_last",  170'(o_last),  170'(0));
    chk("rst_data",  170'(o_data),  170'(0));
    chk("rst_row",   170'(o_row),   170'(0));
    chk("rst_col",   170'(o_col),   170'(0));
    chk("rst_addr",  170'(o_addr),  170'(0));
    chk("rst_we",    170'(o_we),    170'(0));
  endtask

  // Entered and left on a falling edge with the selected DUT idle.
  task automatic sweep(input bit rnd, input int restart_at,
                       input int abort_at, input int stall_at);
    int pad, ow, tot, b, k, n_done, done_k, last_k;
    int stall_left, stall_i, budget;
    bit restarted, stalled, held, in_stall;
    logic [161:0] head, held_v;
    pad = sel ? 1 : 0;
    ow = W + 2 * pad;
    tot = ow * (H + 2 * pad);
    b = 0; n_done = 0; done_k = -1; last_k = -1;
    stall_left = 0; stall_i = 0;
    restarted = 0; stalled = 0; held = 0; held_v = '0;
    budget = 6 * tot + 100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk("busy_k1",  170'(o_busy),  170'(1));
    chk("valid_k1", 170'(o_valid), 170'(0));
    while (k <= budget) begin
      if (abort_at >= 0 && b == abort_at) begin
        #2 rst = 1'b1;
        #1 reset_vals();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (stall_at >= 0 && b == stall_at && !stalled) begin
        stalled = 1;
        stall_left = 20;
      end
      in_stall = (stall_left > 0);
      if (in_stall) begin
        ready = 1'b0;
        stall_left--;
        stall_i++;
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (in_stall && stall_i >= 3)
        chk("stall_addr", 170'(o_addr), 170'(last_int_addr(pad, b + 1)));
      if (restart_at >= 0 && b == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      head = {o_last, o_row, o_col, o_data};
      if (held) chk("stable", 170'({o_valid, head}), 170'({1'b1, held_v}));
      if (k == 2) chk("valid_k2", 170'(o_valid), 170'(1));
      if (o_valid && ready) begin
        chk("beat_data", 170'(o_data), 170'(exp_data(pad, b)));
        chk("beat_row", 170'(o_row), 170'(b / ow));
        chk("beat_col", 170'(o_col), 170'(b % ow));
        chk("beat_last", 170'(o_last), 170'(b == tot - 1));
        if (pad == 1 && b == 59) chk("word0_at_59", 170'(o_data), 170'(mem[0]));
        if (b == tot - 1) last_k = k;
        b++;
      end
      held = o_valid && !ready;
      held_v = head;
      if (o_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) chk("busy_fall", 170'(o_busy), 170'(0));
      if (done_k >= 0 && k == done_k + 4) break;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_seen", 170'(done_k >= 0), 170'(1));
    chk("beat_count", 170'(b), 170'(tot));
    chk("done_count", 170'(n_done), 170'(1));
    if (!rnd) begin
      chk("last_cycle", 170'(last_k), 170'(tot + 1));
      chk("done_cycle", 170'(done_k), 170'(tot + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++)
      mem[i] = BPW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_vals();
    sel = 1'b1;
    #1 reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sel = 1'b0;
    sweep(1'b0, -1, -1, -1);

    sel = 1'b1;
    sweep(1'b0, 100, -1, -1);
    sweep(1'b1, -1, -1, 1000);
    sweep(1'b1, -1, 500, -1);
    sweep(1'b0, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_i_fetch.md
# sram_i_fetch

Read-side sequencer for the input feature SRAM (3136 words × 145 bits, one word per spatial position of a 56×56 map, raster order). It sweeps the SRAM address space after a start pulse and absorbs the SRAM's one-cycle registered read latency. It optionally inserts a one-pixel zero border for 3×3 same-padding convolution. It delivers one word per beat to the downstream convolution datapath over a valid/ready stream with row/column tags.

## Interface
- `MAP_W`, 56: feature map width, in words.
- `MAP_H`, 56: feature map height, in words.
- `BIT_PER_WORD`, 145: SRAM word width.
- `ADDR_W`, 12: SRAM address width, equal to clog2(MAP_W*MAP_H).
- `PAD`, 1: border width. Legal values are 0 and 1. When 1, the block emits a zero border around the map.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a sweep. Accepted only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until the cycle `done` pulses, inclusive.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `sram_addr` out ADDR_W: SRAM read address.
- `sram_we` out 1: SRAM write enable. Constant 0.
- `sram_dout` in BIT_PER_WORD: SRAM read data. Valid one cycle after `sram_addr`.
- `pix_data` out BIT_PER_WORD: stream data.
- `pix_row` out 8: output-grid row of the current beat.
- `pix_col` out 8: output-grid column of the current beat.
- `pix_last` out 1: high on the final beat of a sweep.
- `pix_valid` out 1: stream valid.
- `pix_ready` in 1: stream ready from downstream.

## Operation
- Output grid is OH = MAP_H+2·PAD rows by OW = MAP_W+2·PAD columns, scanned in raster order: col increments fastest, wrapping to 0 and incrementing row.
- Position (r,c) is interior when PAD ≤ r < MAP_H+PAD and PAD ≤ c < MAP_W+PAD. An interior position reads sram_addr = (r−PAD)·MAP_W + (c−PAD), computed by incremental counters, with no multiplier. All other positions are pad beats with pix_data = 0.
- FSM states:
  - IDLE: waits for `start`, then moves to RUN.
  - RUN: issues positions. After the last position is issued, moves to DRAIN.
  - DRAIN: waits until the FIFO is empty and the last beat has been accepted, then moves to DONE.
  - DONE: lasts one cycle, pulses `done`, then returns to IDLE.
- Issue pipeline:
  - Stage 0 issues one position per cycle (address plus pad flag plus row/col tags) when credit is available.
  - Stage 1, one cycle later, writes into a 2-entry output FIFO. The stored data is sram_dout for an interior position and 0 for a pad beat.
  - Pad beats traverse the same 1-cycle stage, so beat order always equals issue order.
- Credit rule: issue only when FIFO occupancy + in-flight count (0 or 1) < 2. The FIFO therefore never overflows, and `pix_ready` never combinationally reaches `sram_addr`.
- `sram_addr` holds its last value on cycles with no issue and on pad issues. It is 0 in IDLE.
- Stream handshake:
  - `pix_valid` is high whenever the FIFO is non-empty.
  - `pix_data`, `pix_row`, `pix_col` and `pix_last` come from the FIFO head and are stable while valid is high and ready is low.
  - A beat transfers on valid && ready.
- FIFO push and pop in the same cycle are allowed and leave occupancy unchanged.
- `start` while busy is ignored and does not restart or extend the sweep.
- `rst` in any state: FSM goes to IDLE, FIFO empties, the in-flight flag clears, counters zero. Any partial sweep is abandoned, with no done pulse.

## Timing
- Reset values: busy=0, done=0, pix_valid=0, pix_last=0, pix_data=0, pix_row=0, pix_col=0, sram_addr=0, sram_we=0.
- Start accepted at edge N:
  - busy=1 and the first issue happen in cycle N+1.
  - First pix_valid occurs in cycle N+2.
- With pix_ready held at 1, there is one beat per cycle. The last beat is in cycle N+1+OH·OW, and done pulses in the following cycle.
  - PAD=0: 3136 beats, last beat at N+3137, done at N+3138.
  - PAD=1: 3364 beats.
- With pix_ready low, at most 2 beats are buffered and issue stalls.
  - After pix_ready rises, the next beat appears the same cycle it is accepted from the FIFO head.
  - The pipeline refills without bubbles when ready stays high.
- busy falls in the cycle after done.

## Test plan
- PAD=0, ready=1, start pulse: expect 3136 beats in consecutive cycles, where beat k equals SRAM word k with row=k/56 and col=k%56. pix_last is high only on beat 3135, done pulses once, and the run takes 3138 cycles from start.
- PAD=1, ready=1: expect 3364 beats. Beats 0..58 are zero, beat 59 (row 1, col 1) equals word 0, and beat 3305 (row 56, col 57) is zero. The final beat is row 57, col 57 with pix_last=1.
- PAD=1 with random 50% pix_ready: the received sequence is identical to the ready=1 run. Data is stable while stalled, and the FIFO never overflows (scoreboard check).
- Hold pix_ready=0 for 20 cycles mid-sweep: exactly 2 beats are buffered, sram_addr is frozen, and the stream resumes with no loss or duplication.
- Pulse start again at beat 100: the sweep is unaffected and only one done pulse occurs.
- Assert rst at beat 500: all outputs return to their reset values immediately. A fresh start then produces a complete sweep from beat 0.
